// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter sharing one single-port data memory.
// Round-robin or fixed priority; one access per two cycles.
module dmem_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 19,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              we_q;
  logic              last_grant_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              e0_s;
  logic              e1_s;
  logic              any_req_s;
  logic              gnt_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Winner selection; a port is masked during its own ack cycle.
  always_comb begin
    e0_s      = req0 & ~ack0_q;
    e1_s      = req1 & ~ack1_q;
    any_req_s = e0_s | e1_s;
    gnt_d     = 1'b0;
    if (e0_s && e1_s) begin
      if (FIXED_PRI != 0) begin
        gnt_d = 1'b0;
      end else begin
        gnt_d = ~last_grant_q;
      end
    end else if (e1_s) begin
      gnt_d = 1'b1;
    end else begin
      gnt_d = 1'b0;
    end
    if (gnt_d) begin
      we_d    = we1;
      addr_d  = addr1;
      wdata_d = wdata1;
    end else begin
      we_d    = we0;
      addr_d  = addr0;
      wdata_d = wdata0;
    end
  end

  // Arbiter FSM with registered acks, read data and memory address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      rdata0_q     <= {DATA_W{1'b0}};
      rdata1_q     <= {DATA_W{1'b0}};
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            state_q <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (gnt_q) begin
            ack1_q <= 1'b1;
            if (!we_q) begin
              rdata1_q <= mem_read_data;
            end else begin
              rdata1_q <= rdata1_q;
            end
          end else begin
            ack0_q <= 1'b1;
            if (!we_q) begin
              rdata0_q <= mem_read_data;
            end else begin
              rdata0_q <= rdata0_q;
            end
          end
          last_grant_q <= gnt_q;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by reset so an interrupted access never reaches memory.
  assign busy           = (state_q == ACCESS);
  assign mem_write      = busy & we_q & ~reset;
  assign mem_read       = busy & ~we_q & ~reset;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance,
// each with its own behavioural 16x19 memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0]  addr0 = 4'd0, addr1 = 4'd0;
  logic [18:0] wdata0 = 19'd0, wdata1 = 19'd0;
  logic        ack0, ack1, busy, mem_write, mem_read;
  logic [18:0] rdata0, rdata1, mem_write_data, mem_read_data;
  logic [3:0]  mem_addr;

  logic        f_req0 = 1'b0, f_we0 = 1'b0, f_req1 = 1'b0, f_we1 = 1'b0;
  logic [3:0]  f_addr0 = 4'd0, f_addr1 = 4'd0;
  logic [18:0] f_wdata0 = 19'd0, f_wdata1 = 19'd0;
  logic        f_ack0, f_ack1, f_busy, f_mem_write, f_mem_read;
  logic [18:0] f_rdata0, f_rdata1, f_mem_write_data, f_mem_read_data;
  logic [3:0]  f_mem_addr;

  logic [18:0] mem_m [16];
  logic [18:0] f_mem_m [16];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(4), .DATA_W(19), .FIXED_PRI(0)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.ADDR_W(4), .DATA_W(19), .FIXED_PRI(1)) u_fix (
    .clk(clk), .reset(reset),
    .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0), .ack0(f_ack0), .rdata0(f_rdata0),
    .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .ack1(f_ack1), .rdata1(f_rdata1),
    .busy(f_busy), .mem_addr(f_mem_addr), .mem_write_data(f_mem_write_data),
    .mem_write(f_mem_write), .mem_read(f_mem_read), .mem_read_data(f_mem_read_data)
  );

  assign mem_read_data   = mem_m[mem_addr];
  assign f_mem_read_data = f_mem_m[f_mem_addr];

  // Memory models: preload words 0 and 4, then write on the strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (mem_init) begin
        mem_m[i]   <= (i == 0) ? 19'd5 : ((i == 4) ? 19'd3 : 19'd0);
        f_mem_m[i] <= (i == 0) ? 19'd5 : ((i == 4) ? 19'd3 : 19'd0);
      end
    end
    if (!mem_init && mem_write)   mem_m[mem_addr]     <= mem_write_data;
    if (!mem_init && f_mem_write) f_mem_m[f_mem_addr] <= f_mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    step(); step();
    mem_init = 1'b0;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    chk("rst_maddr_wd", 32'({mem_addr, mem_write_data}), 32'd0);
    reset = 1'b0;

    // Port 0 reads address 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0;
    step();
    chk("rd0_busy", 32'(busy), 32'd1);
    chk("rd0_mem_read", 32'(mem_read), 32'd1);
    chk("rd0_mem_write", 32'(mem_write), 32'd0);
    chk("rd0_ack_early", 32'(ack0), 32'd0);
    step();
    chk("rd0_ack0", 32'(ack0), 32'd1);
    chk("rd0_rdata0", 32'(rdata0), 32'd5);
    chk("rd0_ack1", 32'(ack1), 32'd0);
    chk("rd0_read_one_cycle", 32'(mem_read), 32'd0);
    req0 = 1'b0;
    step();
    chk("drop_ack0_clear", 32'(ack0), 32'd0);
    chk("drop_no_second", 32'({busy, mem_read}), 32'd0);
    step();
    chk("drop_idle", 32'(busy), 32'd0);

    // Port 1 writes 0x12345 to address 9.
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd9; wdata1 = 19'h12345;
    step();
    chk("wr1_strobe", 32'({mem_write, mem_read}), 32'd2);
    chk("wr1_addr", 32'(mem_addr), 32'd9);
    chk("wr1_wdata", 32'(mem_write_data), 32'h12345);
    step();
    chk("wr1_ack1", 32'(ack1), 32'd1);
    chk("wr1_rdata1_kept", 32'(rdata1), 32'd0);
    req1 = 1'b0; we1 = 1'b0;
    step();
    chk("wr1_addr_held", 32'(mem_addr), 32'd9);

    // Both ports read continuously: grants 0,1,0 seen through mem_addr.
    req0 = 1'b1; addr0 = 4'd0; req1 = 1'b1; addr1 = 4'd4;
    step();
    chk("rr_g1_addr", 32'(mem_addr), 32'd0);
    chk("rr_g1_acks", 32'({ack0, ack1}), 32'd0);
    step();
    chk("rr_a1_acks", 32'({ack0, ack1}), 32'd2);
    chk("rr_a1_rdata0", 32'(rdata0), 32'd5);
    step();
    chk("rr_g2_addr", 32'(mem_addr), 32'd4);
    chk("rr_g2_busy", 32'(busy), 32'd1);
    step();
    chk("rr_a2_acks", 32'({ack0, ack1}), 32'd1);
    chk("rr_a2_rdata1", 32'(rdata1), 32'd3);
    step();
    chk("rr_g3_addr", 32'(mem_addr), 32'd0);
    step();
    chk("rr_a3_acks", 32'({ack0, ack1}), 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("rr_end_idle", 32'({busy, ack0, ack1}), 32'd0);

    // Port 0 reads back address 9.
    req0 = 1'b1; addr0 = 4'd9;
    step(); step();
    chk("rb9_ack0", 32'(ack0), 32'd1);
    chk("rb9_rdata0", 32'(rdata0), 32'h12345);
    chk("rb9_rdata1_kept", 32'(rdata1), 32'd3);
    req0 = 1'b0;
    step();

    // Reset lands in the ACCESS cycle of a port-0 write to address 2.
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 19'h7abcd;
    step();
    chk("rstw_pre_write", 32'(mem_write), 32'd1);
    reset = 1'b1; req0 = 1'b0; we0 = 1'b0;
    #1;
    chk("rstw_gated", 32'({mem_write, mem_read}), 32'd0);
    step();
    chk("rstw_no_ack", 32'({ack0, ack1}), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_rdata", 32'({rdata0, rdata1}), 32'd0);
    chk("rstw_maddr_wd", 32'({mem_addr, mem_write_data}), 32'd0);
    chk("rstw_mem2", 32'(mem_m[2]), 32'd0);
    reset = 1'b0;
    req0 = 1'b1; addr0 = 4'd2;
    step(); step();
    chk("rstw_rb_ack0", 32'(ack0), 32'd1);
    chk("rstw_rb_rdata0", 32'(rdata0), 32'd0);
    req0 = 1'b0;
    step();

    // Fixed priority: after a port-0 access, a tie still goes to port 0.
    f_req0 = 1'b1; f_addr0 = 4'd0;
    step(); step();
    chk("fx_first_ack0", 32'(f_ack0), 32'd1);
    f_req0 = 1'b0;
    step();
    f_req0 = 1'b1; f_req1 = 1'b1; f_addr1 = 4'd4;
    step();
    chk("fx_tie_addr", 32'(f_mem_addr), 32'd0);
    step();
    chk("fx_tie_acks", 32'({f_ack0, f_ack1}), 32'd2);
    f_req0 = 1'b0;
    step();
    chk("fx_p1_addr", 32'(f_mem_addr), 32'd4);
    step();
    chk("fx_p1_acks", 32'({f_ack0, f_ack1}), 32'd1);
    chk("fx_p1_rdata1", 32'(f_rdata1), 32'd3);
    f_req1 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
